// File: rtl/exe_pipe_stage_if.sv
// rtl/exe_pipe_stage_if.sv - EXE-to-MEM stage handshake bundle (upstream entry in, downstream entry out)
interface exe_pipe_stage_if #(
    parameter int WORD_W = 32,
    parameter int DST_W  = 4,
    parameter int CTRL_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DST_W-1:0]  in_dst;
    logic [CTRL_W-1:0] in_ctrl;
    logic [WORD_W-1:0] in_alu_res;
    logic [WORD_W-1:0] in_val_rm;
    logic              out_valid;
    logic              out_ready;
    logic [DST_W-1:0]  out_dst;
    logic [CTRL_W-1:0] out_ctrl;
    logic [WORD_W-1:0] out_alu_res;
    logic [WORD_W-1:0] out_val_rm;

    // The stage itself
    modport slave (
        input  in_valid, in_dst, in_ctrl, in_alu_res, in_val_rm, out_ready,
        output in_ready, out_valid, out_dst, out_ctrl, out_alu_res, out_val_rm
    );

    // The surrounding pipeline (EXE producer and MEM consumer)
    modport master (
        output in_valid, in_dst, in_ctrl, in_alu_res, in_val_rm, out_ready,
        input  in_ready, out_valid, out_dst, out_ctrl, out_alu_res, out_val_rm
    );
endinterface

// File: rtl/exe_pipe_stage.sv
// rtl/exe_pipe_stage.sv - EXE-to-MEM stage register with valid/ready, flush; EXE_PIPE_SKID_EN adds a skid entry
module exe_pipe_stage #(
    parameter int WORD_W = 32,
    parameter int DST_W  = 4,
    parameter int CTRL_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    exe_pipe_stage_if.slave bus
);
    typedef struct packed {
        logic [DST_W-1:0]  dst;
        logic [CTRL_W-1:0] ctrl;
        logic [WORD_W-1:0] alu_res;
        logic [WORD_W-1:0] val_rm;
    } entry_t;

    entry_t in_ent;
    entry_t main_q, main_d;
    logic   main_valid_q, main_valid_d;
    logic   in_ready;
    logic   accept;
    logic   retire;

    assign in_ent = {bus.in_dst, bus.in_ctrl, bus.in_alu_res, bus.in_val_rm};
    assign accept = bus.in_valid && in_ready;
    assign retire = main_valid_q && bus.out_ready;

`ifdef EXE_PIPE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   rdy_q, rdy_d;

    assign in_ready = rdy_q && !flush;

    // Main always holds the oldest entry; skid is only occupied while main is full.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_d.ctrl  = '0;
            skid_valid_d = 1'b0;
            skid_d.ctrl  = '0;
        end else if (!main_valid_q || retire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                if (accept) begin
                    skid_d = in_ent;
                end else begin
                    skid_valid_d = 1'b0;
                    skid_d.ctrl  = '0;
                end
            end else if (accept) begin
                main_d       = in_ent;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
                main_d.ctrl  = '0;
            end
        end else if (accept) begin
            skid_d       = in_ent;
            skid_valid_d = 1'b1;
        end
        rdy_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
        end
    end
`else
    assign in_ready = !flush && (!main_valid_q || bus.out_ready);

    // Payload only moves on accept; ctrl is zeroed whenever the entry goes invalid.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_d.ctrl  = '0;
        end else if (accept) begin
            main_d       = in_ent;
            main_valid_d = 1'b1;
        end else if (retire) begin
            main_valid_d = 1'b0;
            main_d.ctrl  = '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_dst     = main_q.dst;
    assign bus.out_ctrl    = main_q.ctrl;
    assign bus.out_alu_res = main_q.alu_res;
    assign bus.out_val_rm  = main_q.val_rm;
endmodule
